// File: rtl/pipe3_pkg.sv
// Shared definitions for the 3-stage issue controller: instruction field
// positions, opcodes, FSM states and the scoreboard slot record.
package pipe3_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [3:0] rd;
  } slot_t;

  // Only ALU opcodes (everything except NOP and HALT) write rd.
  function automatic logic op_writes(input logic [3:0] op);
    return (op != OP_NOP) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/pipe3_hazard_unit.sv
// Read-after-write detector: flags an ALU instruction whose sources match the
// destination of a writing instruction still in EX or WB.
module pipe3_hazard_unit
  import pipe3_pkg::*;
(
  input  logic [3:0] op,
  input  logic [3:0] rs1,
  input  logic [3:0] rs2,
  input  slot_t      ex_slot,
  input  slot_t      wb_slot,
  output logic       hazard
);

  // r0 is hardwired zero, so a pending write to it never blocks a reader.
  function automatic logic pending_write(input slot_t s, input logic [3:0] rs);
    return s.valid && op_writes(s.op) && (s.rd != 4'd0) && (s.rd == rs);
  endfunction

  always_comb begin
    hazard = op_writes(op) &&
             (pending_write(ex_slot, rs1) || pending_write(ex_slot, rs2) ||
              pending_write(wb_slot, rs1) || pending_write(wb_slot, rs2));
  end

endmodule

// File: rtl/pipe3_issue_ctrl.sv
// Issue controller for a 3-stage datapath: combinational issue, EX/WB
// scoreboard, RAW stall insertion and HALT draining.
//
//   state     | meaning
//   ST_RUN    | accepting instructions unless a hazard is present
//   ST_DRAIN  | HALT accepted, waiting for EX and WB to empty
//   ST_HALTED | pipeline empty, no further issue until reset
module pipe3_issue_ctrl
  import pipe3_pkg::*;
#(
  parameter int RA_W = 4,
  parameter int SC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [15:0]     in_instr,
  output logic            in_ready,
  output logic            iss_valid,
  output logic [3:0]      iss_op,
  output logic [3:0]      iss_rd,
  output logic [3:0]      iss_rs1,
  output logic [3:0]      iss_rs2,
  output logic            wb_en,
  output logic [RA_W-1:0] wb_addr,
  output logic [SC_W-1:0] stall_cnt,
  output logic            busy,
  output logic            halted
);

  state_e          state_q, state_d;
  slot_t           ex_q, ex_d;
  slot_t           wb_q, wb_d;
  logic [SC_W-1:0] stall_q, stall_d;
  logic            hazard;

  assign iss_op  = in_instr[OP_MSB:OP_LSB];
  assign iss_rd  = in_instr[RD_MSB:RD_LSB];
  assign iss_rs1 = in_instr[RS1_MSB:RS1_LSB];
  assign iss_rs2 = in_instr[RS2_MSB:RS2_LSB];

  pipe3_hazard_unit u_hazard (
    .op      (iss_op),
    .rs1     (iss_rs1),
    .rs2     (iss_rs2),
    .ex_slot (ex_q),
    .wb_slot (wb_q),
    .hazard  (hazard)
  );

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    in_ready  = 1'b0;
    iss_valid = 1'b0;
    ex_d      = '0;
    wb_d      = ex_q;

    case (state_q)
      ST_RUN: begin
        in_ready = !hazard;
        if (in_valid && hazard && (stall_q != {SC_W{1'b1}})) begin
          stall_d = stall_q + 1'b1;
        end
      end
      // Nothing issues here, so once EX is empty both slots are empty next cycle.
      ST_DRAIN: begin
        if (!ex_q.valid) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      in_ready = 1'b0;
    end

    iss_valid = in_valid && in_ready;
    if (iss_valid) begin
      ex_d.valid = 1'b1;
      ex_d.op    = iss_op;
      ex_d.rd    = iss_rd;
      if (iss_op == OP_HALT) begin
        state_d = ST_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      wb_q    <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
    end
  end

  assign wb_en     = !rst && wb_q.valid && op_writes(wb_q.op);
  assign wb_addr   = RA_W'(wb_q.rd);
  assign stall_cnt = stall_q;
  assign busy      = !rst && (ex_q.valid || wb_q.valid || (state_q == ST_DRAIN));
  assign halted    = !rst && (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipe3_issue_ctrl.sv
// Bench for pipe3_issue_ctrl: directed scenarios plus random traffic, checked
// against a cycle-indexed reference model and a write-back scoreboard.
module tb_pipe3_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic        in_ready, iss_valid, wb_en, busy, halted;
  logic [3:0]  iss_op, iss_rd, iss_rs1, iss_rs2;
  logic [3:0]  wb_addr;
  logic [15:0] stall_cnt;

  pipe3_issue_ctrl #(.RA_W(4), .SC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .iss_valid (iss_valid),
    .iss_op    (iss_op),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .stall_cnt (stall_cnt),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: cycle of the latest accepted writer per register,
  // HALT acceptance cycle, stall count, and recent acceptance history.
  typedef struct {
    int         due;
    logic [3:0] addr;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int      pend[16];
  int      halt_at;
  int      stall_m;
  bit      acc1, acc2;

  function automatic bit is_alu(input logic [3:0] op);
    return (op != 4'h0) && (op != 4'hF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = -100;
    halt_at = -1;
    stall_m = 0;
    acc1    = 1'b0;
    acc2    = 1'b0;
    exp_q.delete();
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input bit v, input logic [15:0] ins, input bit r, output bit dut_acc);
    bit         haz, rdy_e, acc;
    int         t;
    logic [3:0] op, rd, rs1, rs2;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    in_instr = ins;
    if (r) model_reset();
    @(negedge clk);
    t       = cyc;
    acc     = 1'b0;
    dut_acc = v && in_ready;
    op  = ins[15:12];
    rd  = ins[11:8];
    rs1 = ins[7:4];
    rs2 = ins[3:0];
    if (r) begin
      dut_acc = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_iss_valid", 32'(iss_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
    end else begin
      haz   = is_alu(op) && (((rs1 != 4'd0) && (t - pend[rs1] <= 2)) ||
                             ((rs2 != 4'd0) && (t - pend[rs2] <= 2)));
      rdy_e = (halt_at < 0) && !haz;
      acc   = v && rdy_e;
      chk("in_ready", 32'(in_ready), 32'(rdy_e));
      chk("iss_valid", 32'(iss_valid), 32'(acc));
      chk("busy", 32'(busy), 32'(acc1 || acc2));
      chk("halted", 32'(halted), 32'((halt_at >= 0) && (t >= halt_at + 3)));
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
      if (acc) chk("iss_fields", 32'({iss_op, iss_rd, iss_rs1, iss_rs2}), 32'(ins));
      if (v && (halt_at < 0) && haz && (stall_m < 65535)) stall_m++;
      if (acc) begin
        if (is_alu(op)) begin
          exp_q.push_back('{t + 2, rd});
          if (rd != 4'd0) pend[rd] = t;
        end
        if (op == 4'hF) halt_at = t;
      end
    end
    acc2 = acc1;
    acc1 = acc;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, a);
  endtask

  // Offer one instruction until the DUT takes it; waits = stall cycles seen.
  task automatic send(input logic [15:0] ins, output int waits);
    bit a;
    bit done;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      step(1'b1, ins, 1'b0, a);
      if (a) done = 1'b1;
      else waits++;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Write-back monitor, independent of the stimulus process.
  bit mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      chk("wb_en_rst", 32'(wb_en), 32'd0);
    end else begin
      mon_exp = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("wb_en", 32'(wb_en), 32'(mon_exp));
      if (mon_exp) begin
        if (wb_en) chk("wb_addr", 32'(wb_addr), 32'(exp_q[0].addr));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit         a;
    int         w;
    logic [3:0] op;
    int         sel;
    model_reset();

    step(1'b0, 16'h0, 1'b1, a);
    step(1'b0, 16'h0, 1'b1, a);
    chk("rst_stall_cnt_after", 32'(stall_cnt), 32'd0);
    step(1'b0, 16'h0, 1'b0, a);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Independent back-to-back pair
    step(1'b1, 16'h1123, 1'b0, a);
    chk("ind_first_acc", 32'(a), 32'd1);
    step(1'b1, 16'h1456, 1'b0, a);
    chk("ind_second_acc", 32'(a), 32'd1);
    idle(4);
    chk("ind_stall", 32'(stall_cnt), 32'd0);

    // RAW back-to-back, then separated by one NOP
    send(16'h1312, w);
    send(16'h2431, w);
    chk("raw_wait", 32'(w), 32'd2);
    idle(3);
    chk("raw_stall", 32'(stall_cnt), 32'd2);
    send(16'h1312, w);
    send(16'h0000, w);
    send(16'h2431, w);
    chk("raw_nop_wait", 32'(w), 32'd1);
    idle(3);
    chk("raw_nop_stall", 32'(stall_cnt), 32'd3);
    send(16'h1312, w);
    send(16'h0000, w);
    send(16'h0000, w);
    send(16'h2431, w);
    chk("raw_two_sep_wait", 32'(w), 32'd0);

    // Write to r0 never blocks a reader of r0
    send(16'h1012, w);
    send(16'h2500, w);
    chk("r0_wait", 32'(w), 32'd0);
    idle(3);
    chk("r0_stall", 32'(stall_cnt), 32'd3);

    // Reset the cycle after accepting a write to r7
    send(16'h1700, w);
    step(1'b0, 16'h0, 1'b1, a);
    idle(4);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);

    // HALT drain, then ignored input
    send(16'h1123, w);
    send(16'hF000, w);
    chk("halt_wait", 32'(w), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1456, 1'b0, a);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    step(1'b1, 16'h1456, 1'b0, a);
    chk("halt_ignored", 32'(a), 32'd0);

    // Reset from HALTED, then reset during DRAIN
    step(1'b0, 16'h0, 1'b1, a);
    send(16'h1123, w);
    chk("post_halt_accept", 32'(w), 32'd0);
    send(16'hF000, w);
    step(1'b0, 16'h0, 1'b1, a);
    step(1'b1, 16'h1456, 1'b0, a);
    chk("drain_rst_accept", 32'(a), 32'd1);
    idle(3);

    // Random traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 800; n++) begin
      if (((halt_at >= 0) && (cyc > halt_at + 5)) || ($urandom_range(0, 59) == 0)) begin
        step(1'b0, 16'h0, 1'b1, a);
      end else begin
        sel = int'($urandom_range(0, 19));
        if (sel == 0) op = 4'h0;
        else if (sel == 1) op = 4'hF;
        else op = 4'($urandom_range(1, 14));
        step($urandom_range(0, 3) != 0,
             {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
             1'b0, a);
      end
    end

    idle(4);
    chk("wb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe3_issue_ctrl.md
PIPE3_ISSUE_CTRL -- requirements
Module: pipe3_issue_ctrl

Interface
REQ-001 Parameter: RA_W, 4, register-address width (16-entry register file).
REQ-002 Parameter: SC_W, 16, stall-counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  instruction offered.
REQ-006 in_instr  in  16  [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-007 in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready.
REQ-008 iss_valid  out  1  issue to stage 1 (register read) of the 3-stage datapath.
REQ-009 iss_op/iss_rd/iss_rs1/iss_rs2  out  4 each  fields of the issued instruction.
REQ-010 wb_en  out  1  register-file write enable for the stage-3 instruction.
REQ-011 wb_addr  out  RA_W  register-file write address.
REQ-012 stall_cnt  out  SC_W  count of hazard-stall cycles.
REQ-013 busy  out  1  any instruction in flight or draining.
REQ-014 halted  out  1  HALT retired; no further issue.

Function
REQ-015 Opcodes: 0x0 NOP (no write), 0x1-0xE ALU ops writing rd, 0xF HALT (no write).
REQ-016 Issue is combinational: iss_valid = in_valid && in_ready; iss_* fields equal in_instr fields in that cycle.
REQ-017 Scoreboard holds EX slot and WB slot (valid, op, rd); each edge: EX <= issued instr (or bubble), WB <= EX.
REQ-018 Latency: instruction accepted cycle N occupies EX in N+1, WB in N+2; wb_en=1, wb_addr=rd in N+2 iff op writes.
REQ-019 Hazard: in_instr op is ALU and (rs1 or rs2) equals rd of a valid writing instruction in EX or WB, with that rd != 0.
REQ-020 r0 is hardwired zero: writes to rd=0 never create hazards; wb_en still follows REQ-018.
REQ-021 NOP and HALT never hazard.
REQ-022 Hazard forces in_ready=0 and a bubble into EX; dependent pair back-to-back stalls exactly 2 cycles, 1 cycle if separated by one instruction, 0 if by two.
REQ-023 stall_cnt increments each cycle in RUN with in_valid=1 and hazard=1; saturates at 2^SC_W-1.
REQ-024 FSM states RUN, DRAIN, HALTED; RUN: in_ready = !hazard.
REQ-025 RUN->DRAIN when HALT is accepted; DRAIN: in_ready=0; DRAIN->HALTED when EX and WB both empty.
REQ-026 HALTED: in_ready=0, halted=1, stays until rst.
REQ-027 busy = EX.valid || WB.valid || state==DRAIN.
REQ-028 in_valid=0 in RUN inserts a bubble, no stall counted.

Reset
REQ-029 rst sampled at edge: state<=RUN, EX/WB slots invalid, stall_cnt<=0, halted<=0.
REQ-030 While rst=1: in_ready=0, iss_valid=0, wb_en=0, busy=0; in-flight instructions discarded without write-back.
REQ-031 Reset mid-DRAIN or in HALTED returns to RUN; first accept possible in the cycle after rst deasserts.

Structure
REQ-032 Package pipe3_pkg holds opcode constants (OP_NOP, OP_HALT), instruction field positions, FSM state enum, slot record type.
REQ-033 One sub-module pipe3_hazard_unit: combinational compare of rs1/rs2 against EX/WB slots, outputs hazard.

Verification
REQ-034 Reset: rst=1 two cycles -> in_ready=0, wb_en=0, stall_cnt=0, busy=0; after release in_ready=1.
REQ-035 Independent stream: ADD r1,r2,r3 then ADD r4,r5,r6 back-to-back -> both accepted consecutive cycles, wb_en at N+2 (wb_addr=1) and N+3 (wb_addr=4), stall_cnt=0.
REQ-036 RAW: ADD r3,r1,r2 then SUB r4,r3,r1 -> second accepted 2 cycles late, stall_cnt=2; with one NOP between -> stall_cnt=1.
REQ-037 r0 write: op 0x1 rd=0 then reader of r0 -> no stall, stall_cnt unchanged.
REQ-038 HALT: ADD r1 then HALT -> in_ready=0 after HALT, busy=1 two cycles, then halted=1, busy=0; further in_valid ignored.
REQ-039 Reset mid-flight: rst pulsed the cycle after accepting ADD r7 -> no wb_en for r7, state RUN, stall_cnt=0.
